// File: rtl/tape_fetch.sv
// Prefetching tape-image feeder: streams SRAM bytes through a small FIFO to the
// TZX player's toggle handshake. Optional underrun counter: TAPE_FETCH_UNDERRUN_EN.
module tape_fetch #(
    parameter int AW = 21,
    parameter int DL = 3
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic          stop,
    input  logic [AW-1:0] size,
    output logic          active,
    output logic          done,
    output logic          memReq,
    output logic [AW-1:0] memA,
    input  logic          memAck,
    input  logic [7:0]    memQ,
    input  logic          plReq,
    output logic          plAck,
    output logic [7:0]    plD,
    output logic [7:0]    underruns
);

    localparam int DEPTH = 1 << DL;

    typedef enum logic {S_IDLE, S_RUN} mainState_t;
    typedef enum logic [1:0] {F_IDLE, F_REQ, F_DRAIN} fetchState_t;

    mainState_t  state;
    fetchState_t fstate;

    logic [7:0]    fifo [DEPTH];
    logic [DL-1:0] wp, rp;
    logic [DL:0]   count;
    logic [AW-1:0] fa, sc, sizeR;

    logic flush, pending, fifoEmpty, push, pop, lastByte;

    assign flush     = start | stop;
    assign pending   = plReq != plAck;
    assign fifoEmpty = count == '0;
    assign push      = (fstate == F_REQ) && memAck && !flush;
    assign pop       = (state == S_RUN) && !flush && pending && !fifoEmpty;
    assign lastByte  = sc == (sizeR - AW'(1));

    // NOTE: the byte storage carries no reset; count/pointers alone define validity.
    always_ff @(posedge clock) begin
        if (push) fifo[wp] <= memQ;
    end

    // Main FSM, FIFO bookkeeping and player service.
    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= S_IDLE;
            active <= 1'b0;
            done   <= 1'b0;
            plAck  <= 1'b0;
            plD    <= '0;
            sc     <= '0;
            sizeR  <= '0;
            wp     <= '0;
            rp     <= '0;
            count  <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                // Resync the ack so a request left over from before start is dropped.
                sizeR  <= size;
                sc     <= '0;
                plAck  <= plReq;
                active <= 1'b1;
                state  <= S_RUN;
                wp     <= '0;
                rp     <= '0;
                count  <= '0;
            end else if (stop) begin
                active <= 1'b0;
                state  <= S_IDLE;
                wp     <= '0;
                rp     <= '0;
                count  <= '0;
            end else begin
                if (push) wp <= wp + 1'b1;
                if (pop) begin
                    rp    <= rp + 1'b1;
                    plD   <= fifo[rp];
                    plAck <= plReq;
                    sc    <= sc + 1'b1;
                end
                count <= count + (DL+1)'(push) - (DL+1)'(pop);
                if (state == S_RUN && (sizeR == '0 || (pop && lastByte))) begin
                    done   <= 1'b1;
                    active <= 1'b0;
                    state  <= S_IDLE;
                end
            end
        end
    end

    // Fetch FSM: one outstanding SRAM read, issued only while the FIFO has room.
    always_ff @(posedge clock) begin
        if (reset) begin
            fstate <= F_IDLE;
            memReq <= 1'b0;
            memA   <= '0;
            fa     <= '0;
        end else begin
            case (fstate)
                F_IDLE: begin
                    if (state == S_RUN && !flush && fa < sizeR && count < (DL+1)'(DEPTH)) begin
                        memA   <= fa;
                        memReq <= 1'b1;
                        fstate <= F_REQ;
                    end
                end
                F_REQ: begin
                    if (flush) begin
                        // An aborted read must still complete on the bus; its data is dropped.
                        if (memAck) begin
                            memReq <= 1'b0;
                            fstate <= F_IDLE;
                        end else begin
                            fstate <= F_DRAIN;
                        end
                    end else if (memAck) begin
                        fa     <= fa + 1'b1;
                        memReq <= 1'b0;
                        fstate <= F_IDLE;
                    end
                end
                F_DRAIN: begin
                    if (memAck) begin
                        memReq <= 1'b0;
                        fstate <= F_IDLE;
                    end
                end
                default: fstate <= F_IDLE;
            endcase
            if (start) fa <= '0;
        end
    end

`ifdef TAPE_FETCH_UNDERRUN_EN
    logic hungry, starved;

    assign hungry = (state == S_RUN) && !flush && pending && fifoEmpty;

    // starved remembers the previous cycle so each starved request counts once.
    always_ff @(posedge clock) begin
        if (reset || start) begin
            underruns <= '0;
            starved   <= 1'b0;
        end else begin
            starved <= hungry;
            if (hungry && !starved && underruns != 8'hFF) underruns <= underruns + 1'b1;
        end
    end
`else
    assign underruns = '0;
`endif

endmodule

// File: tb/tb_tape_fetch.sv
// Scoreboard bench for tape_fetch: SRAM responder model, player driver and
// an ack monitor that pops expected bytes from a queue.
module tb_tape_fetch;

    localparam int AW = 21;
`ifdef TAPE_FETCH_UNDERRUN_EN
    localparam int UR_EXP = 4;
`else
    localparam int UR_EXP = 0;
`endif

    logic          clock = 1'b0;
    logic          reset, start, stop;
    logic [AW-1:0] size;
    logic          active, done, memReq, memAck, plReq, plAck;
    logic [AW-1:0] memA;
    logic [7:0]    memQ, plD, underruns;

    int vectors = 0;
    int miscompares = 0;

    int ackDelay = 2;
    int ackCount = 0;
    int doneCount = 0;
    int reqRise = 0;
    int nextIdx = 0;
    bit ignoreAck = 0;
    int ackLog[$];
    logic [7:0] expQ[$];

    tape_fetch #(.AW(AW), .DL(3)) dut (
        .clock(clock), .reset(reset), .start(start), .stop(stop), .size(size),
        .active(active), .done(done), .memReq(memReq), .memA(memA),
        .memAck(memAck), .memQ(memQ), .plReq(plReq), .plAck(plAck),
        .plD(plD), .underruns(underruns)
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] sram(int a);
        return 8'((a * 37 + 11) ^ (a >> 2));
    endfunction

    task automatic check(string tag, logic [31:0] observed, logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d", tag, observed, expected);
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic doStart(int sz);
        start = 1'b1;
        size  = AW'(sz);
        tick(1);
        start = 1'b0;
        expQ.delete();
        nextIdx = 0;
    endtask

    task automatic doStop();
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
    endtask

    task automatic request();
        plReq = ~plReq;
        expQ.push_back(sram(nextIdx));
        nextIdx++;
    endtask

    task automatic waitAck(int budget, output int cycles);
        cycles = 0;
        while (plAck !== plReq && cycles < budget) begin
            tick(1);
            cycles++;
        end
        if (plAck !== plReq) check("ack_timeout", plAck, plReq);
    endtask

    // SRAM model: acks ackDelay cycles after seeing memReq, data = sram(memA).
    initial begin
        int waitCnt = 0;
        memAck = 1'b0;
        memQ   = '0;
        forever begin
            @(negedge clock);
            if (memAck) begin
                memAck  = 1'b0;
                waitCnt = 0;
            end else if (memReq === 1'b1) begin
                if (waitCnt >= ackDelay) begin
                    memAck = 1'b1;
                    memQ   = sram(int'(memA));
                    ackLog.push_back(int'(memA));
                    ackCount++;
                end else begin
                    waitCnt++;
                end
            end
        end
    end

    // Ack monitor: every plAck toggle must deliver the next expected byte.
    initial begin
        logic prevAck = 1'b0;
        logic prevReq = 1'b0;
        forever begin
            @(negedge clock);
            if (done === 1'b1) doneCount++;
            if (memReq === 1'b1 && prevReq !== 1'b1) reqRise++;
            if (plAck !== prevAck && reset !== 1'b1) begin
                if (ignoreAck) ignoreAck = 0;
                else if (expQ.size() == 0) check("spurious_ack", 1, 0);
                else check("plD", plD, expQ.pop_front());
            end
            prevAck = plAck;
            prevReq = memReq;
        end
    end

    initial begin
        int cyc, d0, r0;
        reset = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        size  = '0;
        plReq = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(1);
        check("rst_active", active, 0);
        check("rst_done", done, 0);
        check("rst_memReq", memReq, 0);
        check("rst_memA", memA, 0);
        check("rst_plAck", plAck, 0);
        check("rst_plD", plD, 0);
        check("rst_underruns", underruns, 0);

        // Basic playback, size 5, slow player.
        ackDelay = 2;
        doStart(5);
        check("t1_active", active, 1);
        tick(40);
        for (int i = 0; i < 5; i++) begin
            request();
            tick(1);
            check("t1_latency", plAck, plReq);
            check("t1_done", done, (i == 4) ? 1 : 0);
            check("t1_active_end", active, (i == 4) ? 0 : 1);
            tick(39);
        end
        check("t1_done_once", doneCount, 1);

        // FIFO fill limit with an idle player.
        ackDelay = 1;
        ackLog.delete();
        ackCount = 0;
        doStart(20);
        tick(100);
        check("t2_fill", ackCount, 8);
        for (int i = 0; i < 8 && i < ackLog.size(); i++) check("t2_addr", ackLog[i], i);
        check("t2_memReq_low", memReq, 0);
        request();
        tick(1);
        check("t2_latency", plAck, plReq);
        tick(30);
        check("t2_refill", ackCount, 9);
        if (ackLog.size() > 8) check("t2_addr8", ackLog[8], 8);
        doStop();
        tick(2);

        // Empty image.
        r0 = reqRise;
        d0 = doneCount;
        doStart(0);
        check("t3_active", active, 1);
        check("t3_done_early", done, 0);
        tick(1);
        check("t3_done", done, 1);
        check("t3_active_low", active, 0);
        tick(10);
        check("t3_no_mem", reqRise - r0, 0);
        check("t3_done_once", doneCount - d0, 1);

        // Stop during an outstanding read, restart while it drains.
        ackDelay = 10;
        doStart(4);
        cyc = 0;
        while (!(memReq === 1'b1 && memA == AW'(1)) && cyc < 200) begin
            tick(1);
            cyc++;
        end
        check("t4_reach_addr1", memA, 1);
        tick(2);
        d0 = doneCount;
        doStop();
        check("t4_active_low", active, 0);
        check("t4_req_held", memReq, 1);
        tick(3);
        check("t4_req_still", memReq, 1);
        ackLog.delete();
        doStart(4);
        for (int i = 0; i < 4; i++) begin
            request();
            waitAck(200, cyc);
            tick(5);
        end
        tick(5);
        check("t4_drain_addr", (ackLog.size() > 0) ? ackLog[0] : -1, 1);
        check("t4_restart_addr", (ackLog.size() > 1) ? ackLog[1] : -1, 0);
        check("t4_done_once", doneCount - d0, 1);

        // Starved player: slow SRAM.
        ackDelay = 30;
        doStart(4);
        check("t5_ur_clear", underruns, 0);
        for (int i = 0; i < 4; i++) begin
            request();
            waitAck(200, cyc);
            check("t5_waited", (cyc > 1) ? 1 : 0, 1);
            tick(5);
        end
        tick(2);
        check("t5_underruns", underruns, UR_EXP);

        // Restart mid-run with a stale request pending.
        ackDelay = 1;
        doStart(10);
        for (int i = 0; i < 3; i++) begin
            request();
            waitAck(50, cyc);
            tick(10);
        end
        d0 = doneCount;
        ignoreAck = 1;
        plReq = ~plReq;
        doStart(10);
        check("t6_resync", plAck, plReq);
        check("t6_active", active, 1);
        for (int i = 0; i < 10; i++) begin
            request();
            waitAck(50, cyc);
            check("t6_done", done, (i == 9) ? 1 : 0);
            tick(8);
        end
        tick(2);
        check("t6_done_once", doneCount - d0, 1);
        check("t6_queue_empty", expQ.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tape_fetch.md
Name: tape_fetch

Overview:
- Upstream feeder for the TZX player's byte handshake.
- Streams a loaded tape image out of external SRAM through a small prefetch FIFO.
- Answers the player's toggle-style request/acknowledge in a fixed number of cycles, so player timing no longer depends on SRAM latency.
- Sits between the SRAM arbiter (memory port) and the tzxplayer `host_tap_in` / `tzx_req` / `tzx_ack` pins.

Parameters:
- AW, 21, byte address / size width.
- DL, 3, log2 of FIFO depth (8 entries).

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse: begin playback from address 0; latches size.
- stop  in  1  one-cycle pulse: abort playback.
- size  in  AW  image length in bytes; sampled only on start.
- active  out  1  high from start until the last byte is served or stop.
- done  out  1  one-cycle pulse when byte size-1 has been acked to the player.
- memReq  out  1  level request; held until memAck.
- memA  out  AW  byte address; stable while memReq is high.
- memAck  in  1  one-cycle pulse; memQ is valid in the same cycle.
- memQ  in  8  read data.
- plReq  in  1  player request; a toggle means one byte is wanted.
- plAck  out  1  acknowledge toggle.
- plD  out  8  byte for the player; valid once plAck == plReq.
- underruns  out  8  saturating underrun count (see Optional Feature).

Behaviour:
- Reset: active=0, done=0, memReq=0, memA=0, plAck=0, plD=0, underruns=0, FIFO empty, fetch FSM F_IDLE, main FSM S_IDLE.
- Main FSM states: S_IDLE, S_RUN.
- start, in any state:
  - Clear FIFO; fetch pointer fa=0; served count sc=0; latch size.
  - plAck <= plReq, so no stale request is served.
  - active=1, go to S_RUN.
  - size==0: done pulses the next cycle, active returns to 0, no memory access.
- Fetch FSM: F_IDLE, F_REQ, F_DRAIN.
  - F_IDLE -> F_REQ when in S_RUN, fa<size and (FIFO count + outstanding) < 2^DL. memA<=fa, memReq<=1.
  - F_REQ on memAck: push memQ, fa<=fa+1, memReq<=0, back to F_IDLE. memReq is low for at least one cycle between requests.
  - stop or start while in F_REQ: go to F_DRAIN. memReq stays high until memAck; that data is discarded. Then F_IDLE; after a start, fetching resumes at address 0.
- Player service, S_RUN only:
  - When plReq != plAck and FIFO non-empty: pop into plD and set plAck<=plReq on the same edge.
  - Latency: exactly 1 cycle from the plReq toggle to the plAck toggle when data is buffered.
  - FIFO empty: hold plAck until a byte arrives. A byte pushed in cycle N is served at edge N+1.
  - Push and pop in the same cycle are allowed; count is unchanged.
- End of image: on the ack of byte sc==size-1, done pulses for 1 cycle, active<=0, back to S_IDLE. Further plReq toggles are ignored.
- stop: active<=0 and S_IDLE next cycle; FIFO cleared; no done pulse. stop and start in the same cycle: start wins.
- Arithmetic: fa and sc are AW bits, never wrap (bounded by size). FIFO pointers are DL bits, wrap modulo 2^DL; count is DL+1 bits.
- In S_IDLE: plD holds its last value, memReq=0 except while in F_DRAIN.

Optional Feature:
- Macro: TAPE_FETCH_UNDERRUN_EN.
- Defined: underruns increments once per player request found pending with the FIFO empty. The count is taken on the first such cycle only. It saturates at 255 and is cleared by reset and start.
- Undefined: underruns is tied to 0 and no counter logic is built.

Test Plan:
- size=5, memAck 2 cycles after memReq, player toggles every 40 cycles -> plD sequence = SRAM[0..4], each plAck toggle 1 cycle after plReq, done pulses once after the 5th ack, active falls in the same cycle.
- size=20, player idle -> exactly 8 memReq handshakes (memA 0..7) and then memReq stays low. After 1 player toggle, exactly one more fetch at memA=8.
- start with size=0 -> done pulses the next cycle, memReq never rises, active high for 1 cycle.
- stop while memReq is high, memAck delayed 10 cycles -> memReq held until memAck, data not pushed, active=0 the cycle after stop. A start pulse afterwards fetches from memA=0.
- memAck delayed 30 cycles, player toggling every 5 cycles, TAPE_FETCH_UNDERRUN_EN defined -> plAck waits for data, served byte is correct, underruns increments by 1 per starved request. Same bench without the macro -> underruns stays 0.
- start pulsed mid-run at byte 3 of 10 -> plAck resynced to plReq, FIFO flushed, next served byte = SRAM[0], done only after 10 further acks.
